store_buffer: RTL and testbench
===============================

# store_buffer

Write-side FIFO between the execute/memory stage and `data_memory`. It queues SB/SH/SW stores from the pipeline and drains at most one store per cycle into the data memory write port. It also checks pending stores against the current load address, raising a stall when a load would read stale memory. Optionally it forwards full-word store data to the load instead of stalling.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, minimum 2.
- `CNT_W`, `$clog2(DEPTH)+1`, width of `count`.

Ports:
- `clk`  in  1  — system clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `st_valid`  in  1  — pipeline presents a store this cycle.
- `st_alucode`  in  6  — `` `ALU_SB ``, `` `ALU_SH `` or `` `ALU_SW ``; any other code with `st_valid` is ignored.
- `st_addr`  in  32  — byte address of the store.
- `st_data`  in  32  — rs2 value; low 8/16/32 bits are used according to the code.
- `st_ready`  out  1  — buffer can accept a store (`!full`).
- `st_misalign`  out  1  — combinational; SH with `addr[0]`=1 or SW with `addr[1:0]`≠0 while `st_valid`.
- `ld_addr`  in  32  — address of the load currently in the memory stage.
- `ld_valid`  in  1  — a load is in the memory stage.
- `ld_hazard`  out  1  — load must stall this cycle.
- `ld_fwd_valid`  out  1  — `ld_fwd_data` replaces `r_data_word` for this load.
- `ld_fwd_data`  out  32  — forwarded word.
- `drain_en`  in  1  — memory write port available this cycle.
- `mem_is_store`  out  1  — drives `data_memory.is_store`.
- `mem_alucode`  out  6  — drives `data_memory.alucode`.
- `mem_w_addr`  out  32  — drives `w_addr`.
- `mem_w_data_byte`  out  8  — drives `w_data_byte`.
- `mem_w_data_half`  out  16  — drives `w_data_half`.
- `mem_w_data_word`  out  32  — drives `w_data_word`.
- `empty`  out  1  — no pending stores; used by FENCE and halt.
- `count`  out  `CNT_W`  — number of occupied entries.

## Operation
- **Storage.** Circular buffer of `DEPTH` entries, each holding {alucode, addr, data}. Head and tail pointers are `log2(DEPTH)` bits wide and wrap modulo `DEPTH`. A separate occupancy counter distinguishes full from empty.
- **Push.** A push occurs when `st_valid && st_ready && legal code && !st_misalign`. The store is written at the tail. A misaligned or illegal store is dropped; `st_misalign` flags it so the trap logic can act.
- **Pop.** A pop occurs when `mem_is_store`, where `mem_is_store = !empty && drain_en`. The `mem_*` outputs show the head entry combinationally. `mem_w_data_byte` and `mem_w_data_half` are the low slices of the stored data.
- **Simultaneous push and pop.** Both happen in the same cycle and `count` is unchanged.
- **When full.** `st_ready`=0 and no push occurs, even if a pop happens in the same cycle.
- **Hazard detection.** Compare `ld_addr[31:2]` against `addr[31:2]` of every occupied entry, including the head being drained this cycle.
  - An overlap with `ld_valid` sets `ld_hazard`=1, unless forwarding applies (see Configuration).
  - When `ld_valid`=0, both `ld_hazard` and `ld_fwd_valid` are 0.
- **Reset.** Pointers and count go to 0. Outputs after reset: `st_ready`=1, `empty`=1, `count`=0, `mem_is_store`=0, `ld_hazard`=0, `ld_fwd_valid`=0, `ld_fwd_data`=0, `mem_*` data=0. Entry contents are don't-care but must not leak to outputs while the buffer is empty.
- **Reset mid-operation.** Pending stores are discarded and are never written to memory.

## Timing
- A push is visible on `mem_*` in the cycle after acceptance, at the earliest. Memory is written at the edge that ends that cycle, so push-to-memory latency is 2 edges.
- A pop on an edge advances the head, and the next entry is presented in the same following cycle. Sustained drain rate is 1 store per cycle.
- `st_ready`, `empty` and `count` are derived from registered state only. They do not depend on `st_valid` or `drain_en` within the cycle.
- `ld_hazard`, `ld_fwd_*` and `st_misalign` are combinational from inputs and registered state, with no added latency.
- Program order is preserved: entries drain strictly oldest first.

## Configuration
- **With `STORE_BUF_FWD_EN` defined:**
  - Find the youngest occupied entry whose word address matches `ld_addr`.
  - If that entry is `` `ALU_SW ``: `ld_fwd_valid`=1, `ld_fwd_data` = its data, and `ld_hazard`=0. The consumer extracts byte or half-word lanes exactly as the memory does.
  - If that entry is SB or SH: `ld_hazard`=1 and `ld_fwd_valid`=0.
- **Without `STORE_BUF_FWD_EN`:** `ld_fwd_valid` and `ld_fwd_data` are tied to 0, and any word-address overlap raises `ld_hazard`.

## Test plan
- **Basic SW drain.** After reset, push SW addr `0x100` data `0xDEADBEEF` with `drain_en`=1.
  - Next cycle: `mem_is_store`=1, `mem_w_addr`=`0x100`, `mem_w_data_word`=`0xDEADBEEF`.
  - Following cycle: `empty`=1.
- **Fill and overflow.** With `DEPTH`=4 and `drain_en`=0, push 4 SB stores.
  - Expect `count`=4, `st_ready`=0.
  - A fifth `st_valid` is not accepted.
  - Raise `drain_en`: entries appear in push order on 4 consecutive cycles.
- **Push while draining.** With `count`=2, push and drain in the same cycle.
  - Expect `count` stays 2 and data order is kept across pointer wrap (addresses `0x0`–`0x1C` cycled twice).
- **Misaligned stores.** SH at `0x103` and SW at `0x102`.
  - Expect `st_misalign`=1, `count` unchanged and no `mem_is_store`.
- **Load hazard and forwarding.** Pending SB `0x201` and SW `0x200` (`0x11223344`, the younger entry); load at `0x202`.
  - With `STORE_BUF_FWD_EN`: `ld_fwd_valid`=1, `ld_fwd_data`=`0x11223344`, `ld_hazard`=0.
  - Without it: `ld_hazard`=1.
  - With only the SB pending: `ld_hazard`=1 in both builds.
- **Reset mid-operation.** Assert `rst` with 3 entries pending.
  - Expect `count`=0, `mem_is_store`=0 immediately.
  - Expect no memory write on subsequent edges.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Write-side FIFO sitting between the execute/memory stage and data_memory.
// Accepted SB/SH/SW stores are queued in program order and drained at most one
// per cycle into the data memory write port. Every occupied entry is compared
// against the word address of the load in the memory stage; a match stalls the
// load so it never reads stale memory.
//
// Optional feature (compile-time macro STORE_BUF_FWD_EN):
//   When defined, the youngest matching entry is inspected. If it is a full
//   word store its data is forwarded to the load and no stall is raised; a
//   matching SB/SH still stalls. When undefined, ld_fwd_* are tied to zero and
//   any word-address overlap stalls.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   CNT_W  width of count ($clog2(DEPTH)+1)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   st_valid/st_alucode/
//   st_addr/st_data          store presented by the pipeline
//   st_ready                 buffer not full (registered state only)
//   st_misalign              SH/SW with misaligned address while st_valid
//   ld_valid/ld_addr         load currently in the memory stage
//   ld_hazard                load must stall this cycle
//   ld_fwd_valid/ld_fwd_data forwarded full word for the load
//   drain_en                 memory write port free this cycle
//   mem_is_store/mem_alucode/
//   mem_w_addr/mem_w_data_*  head entry presented to data_memory
//   empty, count             occupancy status (registered state only)
// -----------------------------------------------------------------------------

`ifndef ALU_SB
`define ALU_SB 6'd20
`endif
`ifndef ALU_SH
`define ALU_SH 6'd21
`endif
`ifndef ALU_SW
`define ALU_SW 6'd22
`endif

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             st_valid,
    input  logic [5:0]       st_alucode,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    output logic             st_misalign,

    input  logic [31:0]      ld_addr,
    input  logic             ld_valid,
    output logic             ld_hazard,
    output logic             ld_fwd_valid,
    output logic [31:0]      ld_fwd_data,

    input  logic             drain_en,
    output logic             mem_is_store,
    output logic [5:0]       mem_alucode,
    output logic [31:0]      mem_w_addr,
    output logic [7:0]       mem_w_data_byte,
    output logic [15:0]      mem_w_data_half,
    output logic [31:0]      mem_w_data_word,

    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    // -------------------------------------------------------------------------
    // Entry storage. Contents are never reset: an entry is only observable
    // while it lies inside the occupied window [head, head+count).
    // -------------------------------------------------------------------------
    logic [5:0]  code_q [DEPTH];
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic legal_code;
    logic push;
    logic pop;

    // -------------------------------------------------------------------------
    // Status derived purely from registered occupancy
    // -------------------------------------------------------------------------
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign st_ready = !full;
    assign count    = count_q;

    // -------------------------------------------------------------------------
    // Store acceptance
    // -------------------------------------------------------------------------
    assign legal_code = (st_alucode == `ALU_SB) ||
                        (st_alucode == `ALU_SH) ||
                        (st_alucode == `ALU_SW);

    assign st_misalign = st_valid &&
                         (((st_alucode == `ALU_SH) && st_addr[0]) ||
                          ((st_alucode == `ALU_SW) && (st_addr[1:0] != 2'b00)));

    // Acceptance uses the registered full flag, so a pop in the same cycle
    // does not free a slot for a push.
    assign push = st_valid && st_ready && legal_code && !st_misalign;
    assign pop  = !empty && drain_en;

    // -------------------------------------------------------------------------
    // Drain port: head entry shown combinationally, forced to zero when empty
    // so stale entry contents never reach the memory interface.
    // -------------------------------------------------------------------------
    assign mem_is_store    = pop;
    assign mem_alucode     = empty ? 6'd0  : code_q[head_q];
    assign mem_w_addr      = empty ? 32'd0 : addr_q[head_q];
    assign mem_w_data_word = empty ? 32'd0 : data_q[head_q];
    assign mem_w_data_half = mem_w_data_word[15:0];
    assign mem_w_data_byte = mem_w_data_word[7:0];

    // -------------------------------------------------------------------------
    // Pointer / occupancy next state
    // -------------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            code_q[tail_q] <= st_alucode;
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

    // -------------------------------------------------------------------------
    // Per-entry occupancy and word-address match against the current load.
    // An entry's age is its distance from head; it is occupied when that
    // distance is below the count. The head being drained this cycle still
    // counts, since memory is not written until the coming edge.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] age;
        assign age       = PTR_W'(gi) - head_q;
        assign occ[gi]   = (CNT_W'(age) < count_q);
        assign match[gi] = occ[gi] && (addr_q[gi][31:2] == ld_addr[31:2]);
    end

    // Byte lane of the load address never affects a word-granular overlap.
    logic unused_ld_lane;
    assign unused_ld_lane = ^ld_addr[1:0];

`ifdef STORE_BUF_FWD_EN
    // -------------------------------------------------------------------------
    // Forwarding: walk entries oldest to youngest so the last hit wins,
    // leaving the youngest matching store selected.
    // -------------------------------------------------------------------------
    logic             yng_hit;
    logic [PTR_W-1:0] yng_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             yng_is_sw;

    always_comb begin
        yng_hit  = 1'b0;
        yng_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (match[scan_idx]) begin
                yng_hit = 1'b1;
                yng_idx = scan_idx;
            end
        end
    end

    assign yng_is_sw    = (code_q[yng_idx] == `ALU_SW);
    assign ld_fwd_valid = ld_valid && yng_hit && yng_is_sw;
    assign ld_hazard    = ld_valid && yng_hit && !yng_is_sw;
    assign ld_fwd_data  = ld_fwd_valid ? data_q[yng_idx] : 32'd0;
`else
    assign ld_hazard    = ld_valid && (|match);
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps

`ifndef ALU_SB
`define ALU_SB 6'd20
`endif
`ifndef ALU_SH
`define ALU_SH 6'd21
`endif
`ifndef ALU_SW
`define ALU_SW 6'd22
`endif

module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             st_valid;
    logic [5:0]       st_alucode;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_ready;
    logic             st_misalign;
    logic [31:0]      ld_addr;
    logic             ld_valid;
    logic             ld_hazard;
    logic             ld_fwd_valid;
    logic [31:0]      ld_fwd_data;
    logic             drain_en;
    logic             mem_is_store;
    logic [5:0]       mem_alucode;
    logic [31:0]      mem_w_addr;
    logic [7:0]       mem_w_data_byte;
    logic [15:0]      mem_w_data_half;
    logic [31:0]      mem_w_data_word;
    logic             empty;
    logic [CNT_W-1:0] count;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_alucode     (st_alucode),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .st_misalign    (st_misalign),
        .ld_addr        (ld_addr),
        .ld_valid       (ld_valid),
        .ld_hazard      (ld_hazard),
        .ld_fwd_valid   (ld_fwd_valid),
        .ld_fwd_data    (ld_fwd_data),
        .drain_en       (drain_en),
        .mem_is_store   (mem_is_store),
        .mem_alucode    (mem_alucode),
        .mem_w_addr     (mem_w_addr),
        .mem_w_data_byte(mem_w_data_byte),
        .mem_w_data_half(mem_w_data_half),
        .mem_w_data_word(mem_w_data_word),
        .empty          (empty),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending stores in program order, oldest at index 0.
    typedef struct packed {
        logic [5:0]  code;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    endtask

    function automatic bit model_legal(input logic [5:0] c);
        return (c == `ALU_SB) || (c == `ALU_SH) || (c == `ALU_SW);
    endfunction

    function automatic bit model_mis(input logic v, input logic [5:0] c, input logic [31:0] a);
        return v && (((c == `ALU_SH) && a[0]) || ((c == `ALU_SW) && (a[1:0] != 2'b00)));
    endfunction

    task automatic drive(input logic sv, input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic dr, input logic lv,
                         input logic [31:0] la);
        st_valid   = sv;
        st_alucode = c;
        st_addr    = a;
        st_data    = d;
        drain_en   = dr;
        ld_valid   = lv;
        ld_addr    = la;
    endtask

    // Mid-cycle compare of every output against the model.
    task automatic settle();
        bit          e_haz, e_fv, e_mis;
        logic [31:0] e_fd;
        ent_t        h;
        #4;
        if (rst) mq.delete();
        e_haz = 1'b0;
        e_fv  = 1'b0;
        e_fd  = 32'd0;
        if (ld_valid) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].addr[31:2] == ld_addr[31:2]) begin
`ifdef STORE_BUF_FWD_EN
                    if (mq[i].code == `ALU_SW) begin
                        e_fv = 1'b1;
                        e_fd = mq[i].data;
                    end else begin
                        e_haz = 1'b1;
                    end
`else
                    e_haz = 1'b1;
`endif
                    break;
                end
            end
        end
        e_mis = model_mis(st_valid, st_alucode, st_addr);
        h = '0;
        if (mq.size() > 0) h = mq[0];
        chk("count",        32'(count),          32'(mq.size()));
        chk("empty",        32'(empty),          32'(mq.size() == 0));
        chk("st_ready",     32'(st_ready),       32'(mq.size() < DEPTH));
        chk("st_misalign",  32'(st_misalign),    32'(e_mis));
        chk("mem_is_store", 32'(mem_is_store),   32'((mq.size() > 0) && drain_en));
        chk("mem_alucode",  32'(mem_alucode),    32'(h.code));
        chk("mem_w_addr",   mem_w_addr,          h.addr);
        chk("mem_w_word",   mem_w_data_word,     h.data);
        chk("mem_w_half",   32'(mem_w_data_half), 32'(h.data[15:0]));
        chk("mem_w_byte",   32'(mem_w_data_byte), 32'(h.data[7:0]));
        chk("ld_hazard",    32'(ld_hazard),      32'(e_haz));
        chk("ld_fwd_valid", 32'(ld_fwd_valid),   32'(e_fv));
        chk("ld_fwd_data",  ld_fwd_data,         e_fd);
    endtask

    // Apply the coming edge to the model, then advance to just after it.
    task automatic finish_cycle();
        int   pre;
        ent_t e;
        if (!rst) begin
            pre = mq.size();
            if (pre > 0 && drain_en) begin
                e = mq.pop_front();
                $display("t=%0t pop  code=%0d addr=0x%08h data=0x%08h", $time, e.code, e.addr, e.data);
            end
            if (st_valid && pre < DEPTH && model_legal(st_alucode) &&
                !model_mis(st_valid, st_alucode, st_addr)) begin
                e.code = st_alucode;
                e.addr = st_addr;
                e.data = st_data;
                mq.push_back(e);
                $display("t=%0t push code=%0d addr=0x%08h data=0x%08h", $time, e.code, e.addr, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic sv, input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic dr);
        drive(sv, c, a, d, dr, 1'b0, 32'd0);
        settle();
        finish_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        settle();
        finish_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        settle();
        finish_cycle();
        rst = 1'b0;

        // Reset state
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
        settle();
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_empty",    32'(empty), 32'd1);
        chk("rst_count",    32'(count), 32'd0);
        chk("rst_mem_is_store", 32'(mem_is_store), 32'd0);
        chk("rst_ld_hazard", 32'(ld_hazard), 32'd0);
        chk("rst_mem_word", mem_w_data_word, 32'd0);
        finish_cycle();

        // Basic SW drain
        cycle(1'b1, `ALU_SW, 32'h100, 32'hDEADBEEF, 1'b1);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        settle();
        chk("sw_mem_is_store", 32'(mem_is_store), 32'd1);
        chk("sw_mem_addr", mem_w_addr, 32'h100);
        chk("sw_mem_word", mem_w_data_word, 32'hDEADBEEF);
        finish_cycle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        settle();
        chk("sw_empty_after", 32'(empty), 32'd1);
        finish_cycle();

        // Fill and overflow
        for (int i = 0; i < 4; i++) cycle(1'b1, `ALU_SB, 32'h300 + 32'(i), 32'(8'hA0 + i), 1'b0);
        drive(1'b1, `ALU_SB, 32'h304, 32'h55, 1'b0, 1'b0, 32'd0);
        settle();
        chk("full_count", 32'(count), 32'd4);
        chk("full_st_ready", 32'(st_ready), 32'd0);
        finish_cycle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        settle();
        chk("full_no_fifth", 32'(count), 32'd4);
        finish_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
            settle();
            chk("drain_order_addr", mem_w_addr, 32'h300 + 32'(i));
            chk("drain_order_byte", 32'(mem_w_data_byte), 32'(8'hA0 + i));
            finish_cycle();
        end

        // Push while draining across pointer wrap
        cycle(1'b1, `ALU_SW, 32'h0, 32'h1000, 1'b0);
        cycle(1'b1, `ALU_SW, 32'h4, 32'h1001, 1'b0);
        for (int i = 2; i < 18; i++) begin
            drive(1'b1, `ALU_SW, 32'((i % 8) * 4), 32'h1000 + 32'(i), 1'b1, 1'b0, 32'd0);
            settle();
            chk("wrap_count", 32'(count), 32'd2);
            chk("wrap_head_addr", mem_w_addr, 32'(((i - 2) % 8) * 4));
            finish_cycle();
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);

        // Misaligned stores
        drive(1'b1, `ALU_SH, 32'h103, 32'h1234, 1'b0, 1'b0, 32'd0);
        settle();
        chk("mis_sh", 32'(st_misalign), 32'd1);
        finish_cycle();
        drive(1'b1, `ALU_SW, 32'h102, 32'h5678, 1'b0, 1'b0, 32'd0);
        settle();
        chk("mis_sw", 32'(st_misalign), 32'd1);
        finish_cycle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        settle();
        chk("mis_count", 32'(count), 32'd0);
        chk("mis_no_store", 32'(mem_is_store), 32'd0);
        finish_cycle();

        // Load hazard and forwarding
        cycle(1'b1, `ALU_SB, 32'h201, 32'h000000AA, 1'b0);
        cycle(1'b1, `ALU_SW, 32'h200, 32'h11223344, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h202);
        settle();
`ifdef STORE_BUF_FWD_EN
        chk("fwd_valid", 32'(ld_fwd_valid), 32'd1);
        chk("fwd_data", ld_fwd_data, 32'h11223344);
        chk("fwd_hazard", 32'(ld_hazard), 32'd0);
`else
        chk("nofwd_hazard", 32'(ld_hazard), 32'd1);
        chk("nofwd_valid", 32'(ld_fwd_valid), 32'd0);
`endif
        finish_cycle();
        do_reset();
        cycle(1'b1, `ALU_SB, 32'h201, 32'h000000AA, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h202);
        settle();
        chk("sb_only_hazard", 32'(ld_hazard), 32'd1);
        chk("sb_only_fwd", 32'(ld_fwd_valid), 32'd0);
        finish_cycle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h202);
        settle();
        chk("no_ld_hazard", 32'(ld_hazard), 32'd0);
        finish_cycle();

        // Reset mid-operation with 3 pending
        cycle(1'b1, `ALU_SH, 32'h400, 32'hBEEF, 1'b0);
        cycle(1'b1, `ALU_SW, 32'h404, 32'hCAFE0000, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_mem_is_store", 32'(mem_is_store), 32'd0);
        settle();
        finish_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
            settle();
            chk("postrst_no_write", 32'(mem_is_store), 32'd0);
            finish_cycle();
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [5:0]  c;
            logic [31:0] a;
            int          r;
            r = $urandom_range(0, 9);
            c = (r < 3) ? `ALU_SB : (r < 6) ? `ALU_SH : (r < 9) ? `ALU_SW : 6'($urandom_range(0, 63));
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) != 0 && c == `ALU_SW) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0 && c == `ALU_SH) a[0] = 1'b0;
            drive($urandom_range(0, 9) < 6, c, a, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))});
            rst = ($urandom_range(0, 199) == 0);
            settle();
            finish_cycle();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
